warp_dispatcher: RTL and testbench

Kernel launch queue and dispatcher in front of the `simd_core` array. Accepts warp launch requests (`kernel_t`) from the host/testbench through a valid/ready port and buffers them in FIFO order. Assigns each request to an idle SIMD core by driving that core's `kernel_in` port. Frees the core when the core reports `is_finished_out`, and reports completed warp IDs upstream.

---
 rtl/warp_dispatcher_pkg.sv | 27 ++
 rtl/warp_dispatcher_kernel_fifo.sv | 59 +++++
 rtl/warp_dispatcher.sv | 167 ++++++++++++++++
 tb/tb_warp_dispatcher.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_dispatcher_pkg.sv
// rtl/warp_dispatcher_pkg.sv - shared kernel launch types and constants
package warp_dispatcher_pkg;

  localparam logic [7:0] THREAD_COUNT = 8'd32;
  localparam int         CORE_COUNT   = 4;
  localparam logic [3:0] IDLE_WARP_ID = 4'hF;

  typedef struct packed {
    logic [3:0]  warp_id;
    logic [7:0]  thread_count;
    logic [31:0] start_pc;
  } kernel_t;

  localparam kernel_t IDLE_KERNEL = '{warp_id: IDLE_WARP_ID, thread_count: 8'd0, start_pc: 32'd0};

  typedef enum logic {
    CORE_IDLE = 1'b0,
    CORE_BUSY = 1'b1
  } core_state_e;

  // A launch is well-formed when it names a real warp and a legal thread count
  function automatic logic kernel_is_legal(input kernel_t k);
    return (k.warp_id != IDLE_WARP_ID) && (k.thread_count != 8'd0) &&
           (k.thread_count <= THREAD_COUNT);
  endfunction

endpackage

// File: rtl/warp_dispatcher_kernel_fifo.sv
// rtl/warp_dispatcher_kernel_fifo.sv - synchronous FIFO of pending kernel launches
module kernel_fifo
  import warp_dispatcher_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  kernel_t                  i_push_data,
  input  logic                     i_pop,
  output kernel_t                  o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  kernel_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // Occupancy never exceeds DEPTH (a power of two), so the MSB alone means full
  assign o_full    = r_count[AW];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; simultaneous push and pop keep the count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/warp_dispatcher.sv
// rtl/warp_dispatcher.sv - warp launch queue and lowest-idle-core dispatcher
module warp_dispatcher
  import warp_dispatcher_pkg::*;
#(
  parameter int CORE_COUNT  = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_submit_valid,
  input  kernel_t                           i_submit_kernel,
  output logic                              o_submit_ready,
  output logic                              o_submit_err,
  output kernel_t [CORE_COUNT-1:0]          o_kernel_out,
  input  logic [CORE_COUNT-1:0]             i_is_finished_in,
  input  logic [CORE_COUNT-1:0][3:0]        i_finished_warp_id_in,
  output logic [15:0]                       o_done_warp_mask,
  output logic                              o_id_mismatch_err,
  output logic [$clog2(QUEUE_DEPTH):0]      o_queue_count,
  output logic                              o_all_idle
);

  core_state_e            r_state [CORE_COUNT];
  core_state_e            w_state_next [CORE_COUNT];
  kernel_t                r_kernel [CORE_COUNT];
  logic [14:0]            r_inflight;
  logic [15:0]            r_done_mask;
  logic                   r_submit_err;
  logic                   r_mismatch;

  logic [CORE_COUNT-1:0]  w_busy;
  logic [CORE_COUNT-1:0]  w_finish;
  logic [CORE_COUNT-1:0]  w_load;
  logic                   w_found;
  logic                   w_accept;
  logic                   w_dup;
  logic                   w_reject;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  kernel_t                w_head;
  logic [14:0]            w_set_mask;
  logic [14:0]            w_clr_mask;
  logic                   w_mismatch;

  kernel_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (i_submit_kernel),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (o_queue_count)
  );

  // Ready comes only from registered occupancy: no bypass when full
  assign o_submit_ready    = !w_fifo_full;
  assign w_accept          = i_submit_valid && o_submit_ready;
  assign w_reject          = !kernel_is_legal(i_submit_kernel) || w_dup;
  assign w_push            = w_accept && !w_reject;
  assign w_pop             = |w_load;
  assign o_all_idle        = w_fifo_empty && !(|w_busy);
  assign o_done_warp_mask  = r_done_mask;
  assign o_submit_err      = r_submit_err;
  assign o_id_mismatch_err = r_mismatch;

  // Per-core state register
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < CORE_COUNT; c++) begin
      if (i_rst) r_state[c] <= CORE_IDLE;
      else       r_state[c] <= w_state_next[c];
    end
  end

  // Per-core next state: idle cores take a dispatch, busy cores wait for finish
  always_comb begin
    for (int c = 0; c < CORE_COUNT; c++) begin
      w_state_next[c] = r_state[c];
      case (r_state[c])
        CORE_IDLE: if (w_load[c])              w_state_next[c] = CORE_BUSY;
        CORE_BUSY: if (i_is_finished_in[c])    w_state_next[c] = CORE_IDLE;
        default:                               w_state_next[c] = CORE_IDLE;
      endcase
    end
  end

  // Per-core outputs: busy flags, qualified finishes, and the held kernel
  always_comb begin
    for (int c = 0; c < CORE_COUNT; c++) begin
      w_busy[c]       = (r_state[c] == CORE_BUSY);
      w_finish[c]     = w_busy[c] && i_is_finished_in[c];
      o_kernel_out[c] = r_kernel[c];
    end
  end

  // Lowest-index idle core receives the FIFO head, at most one per cycle
  always_comb begin
    w_load  = '0;
    w_found = 1'b0;
    for (int c = 0; c < CORE_COUNT; c++) begin
      if (!w_busy[c] && !w_found) begin
        w_load[c] = !w_fifo_empty;
        w_found   = 1'b1;
      end
    end
  end

  // Held kernel copy: loaded on dispatch, back to the idle encoding on finish
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < CORE_COUNT; c++) begin
      if (i_rst)            r_kernel[c] <= IDLE_KERNEL;
      else if (w_load[c])   r_kernel[c] <= w_head;
      else if (w_finish[c]) r_kernel[c] <= IDLE_KERNEL;
    end
  end

  // Duplicate detection against the in-flight bitmap (warp 15 never in flight)
  always_comb begin
    w_dup = 1'b0;
    for (int w = 0; w < 15; w++) begin
      if (r_inflight[w] && (i_submit_kernel.warp_id == 4'(w))) w_dup = 1'b1;
    end
  end

  // In-flight bit to set for an accepted, valid launch
  always_comb begin
    w_set_mask = '0;
    for (int w = 0; w < 15; w++) begin
      if (w_push && (i_submit_kernel.warp_id == 4'(w))) w_set_mask[w] = 1'b1;
    end
  end

  // Warps completing this cycle, and whether any core reported a foreign ID
  always_comb begin
    w_clr_mask = '0;
    w_mismatch = 1'b0;
    for (int c = 0; c < CORE_COUNT; c++) begin
      if (w_finish[c]) begin
        for (int w = 0; w < 15; w++) begin
          if (r_kernel[c].warp_id == 4'(w)) w_clr_mask[w] = 1'b1;
        end
        if (i_finished_warp_id_in[c] != r_kernel[c].warp_id) w_mismatch = 1'b1;
      end
    end
  end

  // In-flight bookkeeping and the registered single-cycle status pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight   <= '0;
      r_done_mask  <= '0;
      r_submit_err <= 1'b0;
      r_mismatch   <= 1'b0;
    end else begin
      r_inflight   <= (r_inflight & ~w_clr_mask) | w_set_mask;
      r_done_mask  <= {1'b0, w_clr_mask};
      r_submit_err <= w_accept && w_reject;
      r_mismatch   <= w_mismatch;
    end
  end

endmodule

// File: tb/tb_warp_dispatcher.sv
// tb/tb_warp_dispatcher.sv - self-checking bench with queue-based reference model
module tb_warp_dispatcher;
  import warp_dispatcher_pkg::*;

  localparam int NC = 4;
  localparam int QD = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sub_valid;
  kernel_t              sub_kernel;
  logic                 sub_ready;
  logic                 sub_err;
  kernel_t [NC-1:0]     kout;
  logic [NC-1:0]        fin;
  logic [NC-1:0][3:0]   fid;
  logic [15:0]          done_mask;
  logic                 mism;
  logic [3:0]           qcount;
  logic                 all_idle;

  int total = 0;
  int bad   = 0;

  // reference model state
  kernel_t     m_q[$];
  kernel_t     m_held [NC];
  bit          m_busy [NC];
  logic [15:0] m_inflight = '0;
  logic [15:0] m_done = '0;
  bit          m_err = 1'b0;
  bit          m_mism = 1'b0;

  warp_dispatcher #(.CORE_COUNT(NC), .QUEUE_DEPTH(QD)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_submit_valid        (sub_valid),
    .i_submit_kernel       (sub_kernel),
    .o_submit_ready        (sub_ready),
    .o_submit_err          (sub_err),
    .o_kernel_out          (kout),
    .i_is_finished_in      (fin),
    .i_finished_warp_id_in (fid),
    .o_done_warp_mask      (done_mask),
    .o_id_mismatch_err     (mism),
    .o_queue_count         (qcount),
    .o_all_idle            (all_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the launch/dispatch/complete rules, using pre-edge state
  task automatic model_step();
    logic [15:0] done;
    bit          mm;
    bit          er;
    bit [NC-1:0] freed;
    int          n0;
    if (rst) begin
      m_q.delete();
      for (int c = 0; c < NC; c++) begin
        m_busy[c] = 1'b0;
        m_held[c] = IDLE_KERNEL;
      end
      m_inflight = '0;
      m_done = '0;
      m_err = 1'b0;
      m_mism = 1'b0;
      return;
    end
    done = '0; mm = 1'b0; er = 1'b0; freed = '0;
    for (int c = 0; c < NC; c++) begin
      if (m_busy[c] && fin[c]) begin
        freed[c] = 1'b1;
        done[m_held[c].warp_id] = 1'b1;
        if (fid[c] != m_held[c].warp_id) mm = 1'b1;
      end
    end
    n0 = m_q.size();
    if (n0 > 0) begin
      for (int c = 0; c < NC; c++) begin
        if (!m_busy[c]) begin
          m_held[c] = m_q.pop_front();
          m_busy[c] = 1'b1;
          break;
        end
      end
    end
    if (sub_valid && n0 < QD) begin
      if (sub_kernel.warp_id == 4'hF || sub_kernel.thread_count == 8'd0 ||
          int'(sub_kernel.thread_count) > int'(THREAD_COUNT) || m_inflight[sub_kernel.warp_id])
        er = 1'b1;
      else begin
        m_q.push_back(sub_kernel);
        m_inflight[sub_kernel.warp_id] = 1'b1;
      end
    end
    m_inflight = m_inflight & ~done;
    for (int c = 0; c < NC; c++) begin
      if (freed[c]) begin
        m_busy[c] = 1'b0;
        m_held[c] = IDLE_KERNEL;
      end
    end
    m_done = done;
    m_err = er;
    m_mism = mm;
  endtask

  task automatic compare();
    for (int c = 0; c < NC; c++)
      chk($sformatf("kernel_out[%0d]", c), kout[c], m_busy[c] ? m_held[c] : IDLE_KERNEL);
    chk("queue_count", qcount, m_q.size());
    chk("submit_ready", sub_ready, m_q.size() < QD);
    chk("all_idle", all_idle, (m_q.size() == 0) && !m_busy[0] && !m_busy[1] && !m_busy[2] && !m_busy[3]);
    chk("done_warp_mask", done_mask, m_done);
    chk("submit_err", sub_err, m_err);
    chk("id_mismatch_err", mism, m_mism);
  endtask

  // Model advances on each edge; outputs are compared shortly after it
  initial forever begin
    @(posedge clk);
    model_step();
    #2;
    compare();
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    sub_valid = 1'b0;
    fin = '0;
    fid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    rst = 1'b0;
  endtask

  task automatic submit(input logic [3:0] w, input logic [7:0] tc, input logic [31:0] pc);
    sub_valid = 1'b1;
    sub_kernel = {w, tc, pc};
    cyc();
    sub_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sub_kernel = IDLE_KERNEL;
    idle_inputs();
    cyc(2);
    rst = 1'b0;
    chk("rst queue_count", qcount, 0);
    chk("rst submit_ready", sub_ready, 1);
    chk("rst all_idle", all_idle, 1);
    chk("rst kernel_out0", kout[0], {4'hF, 8'h00, 32'h0});

    // single launch and completion
    submit(4'd1, 8'd4, 32'h1234_5678);
    chk("t1 kernel_out0 still idle at t+1", kout[0], {4'hF, 8'h00, 32'h0});
    cyc();
    chk("t1 kernel_out0 at t+2", kout[0], {4'd1, 8'd4, 32'h1234_5678});
    fin[0] = 1'b1; fid[0] = 4'd1;
    cyc();
    fin = '0;
    chk("t1 done_warp_mask", done_mask, 16'h0002);
    chk("t1 kernel_out0 idle", kout[0], {4'hF, 8'h00, 32'h0});
    chk("t1 no mismatch", mism, 0);

    // back-to-back launches fill the cores in order
    do_reset();
    for (int w = 1; w <= 6; w++) begin
      submit(4'(w), 8'd8, 32'h100 * w);
      if (w >= 2 && w <= 5) chk("t2 in-order dispatch", kout[w-2].warp_id, 4'(w - 1));
    end
    cyc();
    chk("t2 queue_count", qcount, 2);
    fin[2] = 1'b1; fid[2] = 4'd3;
    cyc();
    fin = '0;
    chk("t2 done warp3", done_mask, 16'h0008);
    cyc();
    chk("t2 core2 gets warp5", kout[2].warp_id, 4'd5);
    chk("t2 queue_count after", qcount, 1);

    // full queue backpressure
    do_reset();
    for (int w = 1; w <= 12; w++) submit(4'(w), 8'd1, 32'(w));
    chk("t3 full count", qcount, 8);
    chk("t3 ready low", sub_ready, 0);
    sub_valid = 1'b1; sub_kernel = {4'd13, 8'd2, 32'hD};
    cyc(2);
    chk("t3 held push count", qcount, 8);
    fin[0] = 1'b1; fid[0] = 4'd1;
    cyc();
    fin = '0;
    chk("t3 no bypass", qcount, 8);
    cyc();
    chk("t3 pop count", qcount, 7);
    chk("t3 ready back", sub_ready, 1);
    chk("t3 core0 gets warp5", kout[0].warp_id, 4'd5);
    cyc();
    sub_valid = 1'b0;
    chk("t3 held push lands", qcount, 8);

    // rejected launches
    do_reset();
    submit(4'd2, 8'd4, 32'h20);
    cyc();
    submit(4'hF, 8'd4, 32'h0);
    chk("t4 err idle id", sub_err, 1);
    submit(4'd3, 8'd0, 32'h0);
    chk("t4 err zero threads", sub_err, 1);
    submit(4'd2, 8'd4, 32'h0);
    chk("t4 err duplicate", sub_err, 1);
    submit(4'd5, 8'd33, 32'h0);
    chk("t4 err too many threads", sub_err, 1);
    chk("t4 count unchanged", qcount, 0);
    submit(4'd6, 8'd32, 32'h0);
    chk("t4 max threads accepted", sub_err, 0);
    chk("t4 count one", qcount, 1);

    // simultaneous completions with an ID mismatch
    do_reset();
    for (int w = 1; w <= 4; w++) submit(4'(w), 8'd4, 32'(w));
    cyc();
    fin[0] = 1'b1; fid[0] = 4'd1;
    fin[3] = 1'b1; fid[3] = 4'd9;
    cyc();
    fin = '0;
    chk("t5 done mask", done_mask, 16'h0012);
    chk("t5 id mismatch", mism, 1);

    // reset mid-operation
    do_reset();
    for (int w = 1; w <= 7; w++) submit(4'(w), 8'd4, 32'(w));
    chk("t6 queued three", qcount, 3);
    rst = 1'b1;
    sub_valid = 1'b1; sub_kernel = {4'd8, 8'd4, 32'h8};
    fin = '1; fid = {4'd4, 4'd3, 4'd2, 4'd1};
    cyc();
    rst = 1'b0;
    idle_inputs();
    chk("t6 count", qcount, 0);
    chk("t6 ready", sub_ready, 1);
    chk("t6 all_idle", all_idle, 1);
    chk("t6 done", done_mask, 16'h0000);
    chk("t6 kernel_out1", kout[1], {4'hF, 8'h00, 32'h0});
    cyc();
    chk("t6 done after", done_mask, 16'h0000);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      sub_valid = $urandom_range(0, 1);
      sub_kernel.warp_id = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      sub_kernel.thread_count = 8'($urandom_range(0, 36));
      sub_kernel.start_pc = $urandom;
      for (int c = 0; c < NC; c++) begin
        fin[c] = ($urandom_range(0, 3) == 0);
        fid[c] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : m_held[c].warp_id;
      end
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
